// File: rtl/cevero_wb_lockstep_checker.sv
// Lockstep write-back checker: buffers each core's regfile writes in a small FIFO,
// pops both heads together and reports mismatch, overflow (desync) and stall timeout.
module cevero_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         nempty_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

  assign empty_o = (wptr_q == rptr_q);
  // Same index with differing wrap bits means the ring is full.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + PW'(push_i);
    rptr_d = rptr_q + PW'(pop_i & ~empty_o);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  assign nempty_nxt_o = (wptr_d != rptr_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

module cevero_wb_lockstep_checker #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64,
  parameter bit IGNORE_X0 = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        flush_i,
  input  logic        we_a_i,
  input  logic [4:0]  waddr_a_i,
  input  logic [31:0] wdata_a_i,
  input  logic        we_b_i,
  input  logic [4:0]  waddr_b_i,
  input  logic [31:0] wdata_b_i,
  output logic        error_o,
  output logic [1:0]  error_code_o,
  output logic [4:0]  err_addr_o,
  output logic [31:0] err_data_a_o,
  output logic [31:0] err_data_b_o,
  output logic [7:0]  err_cnt_o,
  output logic        pending_o
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [1:0] wr_ent, head;
  logic [1:0]    we, push_req, push_ok, ovf, full, empty, nempty_nxt;
  logic          pop, mism, one_ne, tmo_ev;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic        error_q, pending_q;
  logic [1:0]  code_q;
  logic [4:0]  addr_q;
  logic [31:0] data_a_q, data_b_q;
  logic [7:0]  cnt_q;

  assign we     = {we_b_i, we_a_i};
  assign wr_ent = {waddr_b_i, wdata_b_i, waddr_a_i, wdata_a_i};

  for (genvar g = 0; g < 2; g++) begin : g_core
    cevero_wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_ent_t))) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .push_i       (push_ok[g]),
      .pop_i        (pop),
      .din_i        (wr_ent[g]),
      .dout_o       (head[g]),
      .empty_o      (empty[g]),
      .full_o       (full[g]),
      .nempty_nxt_o (nempty_nxt[g])
    );
  end

  always_comb begin
    pop  = ~empty[0] & ~empty[1];
    mism = pop & (head[0] != head[1]);
    for (int i = 0; i < 2; i++) begin
      push_req[i] = enable_i & we[i] & (!IGNORE_X0 || wr_ent[i].addr != 5'd0);
      // A full FIFO can still take a write when its head leaves on the same edge.
      ovf[i]      = push_req[i] & full[i] & ~pop;
      push_ok[i]  = push_req[i] & ~ovf[i];
    end
    one_ne    = empty[0] ^ empty[1];
    tmo_ev    = 1'b0;
    tmo_cnt_d = '0;
    if (TIMEOUT != 0 && one_ne) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_d == TW'(TIMEOUT)) begin
        tmo_ev    = 1'b1;
        tmo_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
      pending_q <= 1'b0;
      code_q    <= 2'b00;
      addr_q    <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      cnt_q     <= '0;
    end else begin
      tmo_cnt_q <= flush_i ? '0 : tmo_cnt_d;
      pending_q <= |nempty_nxt;
      error_q   <= 1'b0;
      if (!flush_i && (|ovf || tmo_ev || mism)) begin
        error_q <= 1'b1;
        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        if (ovf[0]) begin
          code_q <= 2'b10;
          addr_q <= wr_ent[0].addr;
        end else if (ovf[1]) begin
          code_q <= 2'b10;
          addr_q <= wr_ent[1].addr;
        end else if (tmo_ev) begin
          code_q <= 2'b11;
          addr_q <= empty[0] ? head[1].addr : head[0].addr;
        end else begin
          code_q   <= 2'b01;
          addr_q   <= head[0].addr;
          data_a_q <= head[0].data;
          data_b_q <= head[1].data;
        end
      end
    end
  end

  assign error_o      = error_q;
  assign error_code_o = code_q;
  assign err_addr_o   = addr_q;
  assign err_data_a_o = data_a_q;
  assign err_data_b_o = data_b_q;
  assign err_cnt_o    = cnt_q;
  assign pending_o    = pending_q;
endmodule

// File: tb/tb_cevero_wb_lockstep_checker.sv
// Bench for the lockstep write-back checker: directed scenarios then random traffic,
// all outputs compared each cycle against a queue-based reference model.
module tb_cevero_wb_lockstep_checker;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, en, fl, we_a, we_b;
  logic [4:0]  wa, wb;
  logic [31:0] da, db;
  logic        error_o, pending_o;
  logic [1:0]  error_code_o;
  logic [4:0]  err_addr_o;
  logic [31:0] err_data_a_o, err_data_b_o;
  logic [7:0]  err_cnt_o;

  cevero_wb_lockstep_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGNORE_X0(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(fl),
    .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(da),
    .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(db),
    .error_o(error_o), .error_code_o(error_code_o), .err_addr_o(err_addr_o),
    .err_data_a_o(err_data_a_o), .err_data_b_o(err_data_b_o),
    .err_cnt_o(err_cnt_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        qa[$], qb[$], strm[$];
  ent_t        e;
  int          m_tcnt, m_cnt, saved_cnt;
  logic        m_err, m_pend;
  logic [1:0]  m_code;
  logic [4:0]  m_addr;
  logic [31:0] m_da, m_db;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: two queues, popped together when both hold data.
  task automatic model_step();
    bit pop, pa, pb, oa, ob, one, tmo;
    ent_t ha, hb;
    logic [4:0] wait_a;
    if (rst) begin
      qa.delete(); qb.delete();
      m_tcnt = 0; m_err = 0; m_code = 0; m_addr = 0; m_da = 0; m_db = 0; m_cnt = 0; m_pend = 0;
      return;
    end
    pop = qa.size() > 0 && qb.size() > 0;
    ha = pop ? qa[0] : '0;
    hb = pop ? qb[0] : '0;
    pa = en && we_a && wa != 0;
    pb = en && we_b && wb != 0;
    oa = pa && qa.size() == DEPTH && !pop;
    ob = pb && qb.size() == DEPTH && !pop;
    one = (qa.size() > 0) != (qb.size() > 0);
    tmo = 0;
    wait_a = '0;
    if (one) begin
      wait_a = (qa.size() > 0) ? qa[0].a : qb[0].a;
      m_tcnt++;
      if (m_tcnt == TIMEOUT) begin
        tmo = 1;
        m_tcnt = 0;
      end
    end else m_tcnt = 0;
    m_err = 0;
    if (fl) begin
      qa.delete(); qb.delete();
      m_tcnt = 0;
    end else begin
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (pa && !oa) qa.push_back(ent_t'{a: wa, d: da});
      if (pb && !ob) qb.push_back(ent_t'{a: wb, d: db});
      if (oa || ob || tmo || (pop && ha != hb)) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        if (oa) begin m_code = 2; m_addr = wa; end
        else if (ob) begin m_code = 2; m_addr = wb; end
        else if (tmo) begin m_code = 3; m_addr = wait_a; end
        else begin m_code = 1; m_addr = ha.a; m_da = ha.d; m_db = hb.d; end
      end
    end
    m_pend = qa.size() > 0 || qb.size() > 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("error_o", 32'(error_o), 32'(m_err));
    chk("error_code_o", 32'(error_code_o), 32'(m_code));
    chk("err_addr_o", 32'(err_addr_o), 32'(m_addr));
    chk("err_data_a_o", err_data_a_o, m_da);
    chk("err_data_b_o", err_data_b_o, m_db);
    chk("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt));
    chk("pending_o", 32'(pending_o), 32'(m_pend));
  endtask

  task automatic idle(input int n);
    we_a = 0; we_b = 0; fl = 0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1; en = 1; fl = 0; we_a = 0; we_b = 0; wa = 0; wb = 0; da = 0; db = 0;
    tick(); tick();
    chk("rst_cnt", 32'(err_cnt_o), 0);
    chk("rst_pend", 32'(pending_o), 0);
    rst = 0;
    idle(3);

    // 1: matching write
    we_a = 1; wa = 5; da = 32'h1234; we_b = 1; wb = 5; db = 32'h1234;
    tick();
    chk("t1_pend_hi", 32'(pending_o), 1);
    idle(1);
    chk("t1_pend_lo", 32'(pending_o), 0);
    idle(1);
    chk("t1_noerr", 32'(error_o), 0);
    chk("t1_cnt", 32'(err_cnt_o), 0);

    // 2: data mismatch, pulse two cycles after the write
    we_a = 1; wa = 5; da = 32'h1234; we_b = 1; wb = 5; db = 32'h1235;
    tick();
    chk("t2_early", 32'(error_o), 0);
    idle(1);
    chk("t2_err", 32'(error_o), 1);
    chk("t2_code", 32'(error_code_o), 1);
    chk("t2_addr", 32'(err_addr_o), 5);
    chk("t2_da", err_data_a_o, 32'h1234);
    chk("t2_db", err_data_b_o, 32'h1235);
    chk("t2_cnt", 32'(err_cnt_o), 1);
    idle(1);
    chk("t2_once", 32'(error_o), 0);

    // 3: A leads B by three cycles
    for (int c = 0; c < 7; c++) begin
      we_a = (c < 4); wa = 5'(c + 10); da = 32'hA000 + c;
      we_b = (c >= 3); wb = 5'(c + 7); db = 32'hA000 + c - 3;
      tick();
    end
    idle(2);
    chk("t3_pend", 32'(pending_o), 0);
    chk("t3_cnt", 32'(err_cnt_o), 1);

    // 4: five A writes into a four-deep FIFO
    for (int c = 1; c <= 5; c++) begin
      we_a = 1; wa = 5'(c + 20); da = 32'hB0 + c;
      tick();
    end
    chk("t4_err", 32'(error_o), 1);
    chk("t4_code", 32'(error_code_o), 2);
    chk("t4_addr", 32'(err_addr_o), 25);
    we_a = 0; fl = 1; tick();
    idle(1);
    chk("t4_flushed", 32'(pending_o), 0);

    // 5: lone A entry times out periodically
    we_a = 1; wa = 9; da = 32'h99;
    tick();
    idle(63);
    chk("t5_pre", 32'(error_o), 0);
    idle(1);
    chk("t5_pulse", 32'(error_o), 1);
    chk("t5_code", 32'(error_code_o), 3);
    chk("t5_addr", 32'(err_addr_o), 9);
    idle(63);
    chk("t5_pre2", 32'(error_o), 0);
    idle(1);
    chk("t5_pulse2", 32'(error_o), 1);
    fl = 1; tick();
    idle(1);

    // 6: flush discards a pending entry and same-cycle mismatching writes
    we_a = 1; wa = 7; da = 32'h77;
    tick();
    saved_cnt = m_cnt;
    fl = 1; we_a = 1; wa = 3; da = 32'h1; we_b = 1; wb = 3; db = 32'h2;
    tick();
    chk("t6_pend", 32'(pending_o), 0);
    chk("t6_noerr", 32'(error_o), 0);
    idle(3);
    chk("t6_cnt", 32'(err_cnt_o), 32'(saved_cnt));
    we_a = 1; wa = 0; da = 32'h5; we_b = 1; wb = 0; db = 32'h6;
    tick();
    chk("t6_x0_pend", 32'(pending_o), 0);
    idle(2);
    chk("t6_x0_noerr", 32'(err_cnt_o), 32'(saved_cnt));

    // Random lockstep traffic with skew, injected faults, flushes, enables, resets
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      fl   = ($urandom_range(0, 79) == 0);
      en   = ($urandom_range(0, 15) != 0);
      we_a = ($urandom_range(0, 2) == 0);
      wa   = 5'($urandom_range(0, 7));
      da   = $urandom;
      if (we_a && strm.size() < 6) strm.push_back(ent_t'{a: wa, d: da});
      we_b = 0; wb = 0; db = 0;
      if (strm.size() > 0 && $urandom_range(0, 2) == 0) begin
        e = strm.pop_front();
        we_b = 1; wb = e.a; db = e.d;
        if ($urandom_range(0, 15) == 0) db = db ^ (32'h1 << $urandom_range(0, 31));
      end
      tick();
    end
    rst = 0; en = 1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
